// File: rtl/useq_mbox_if.sv
// Host/sequencer mailbox bus.
//   master : drives host_wr/host_wdata/host_rd, seq_wr/seq_wdata/seq_rd, clr_err;
//            observes read data, valids, flags, counts, irqs and err.
//   slave  : the mailbox itself (mirror of master).
interface useq_mbox_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  // host side
  logic              host_wr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_rd;
  logic [DATA_W-1:0] host_rdata;
  logic              host_rvld;
  logic              host_full;
  logic              host_empty;
  logic              host_irq;

  // sequencer side
  logic              seq_wr;
  logic [DATA_W-1:0] seq_wdata;
  logic              seq_rd;
  logic [DATA_W-1:0] seq_rdata;
  logic              seq_rvld;
  logic              seq_full;
  logic              seq_empty;
  logic              seq_irq;

  // status
  logic [CW-1:0]     h2s_count;
  logic [CW-1:0]     s2h_count;
  logic [3:0]        err;
  logic              clr_err;

  modport master (
    output host_wr, host_wdata, host_rd,
    output seq_wr, seq_wdata, seq_rd,
    output clr_err,
    input  host_rdata, host_rvld, host_full, host_empty, host_irq,
    input  seq_rdata, seq_rvld, seq_full, seq_empty, seq_irq,
    input  h2s_count, s2h_count, err
  );

  modport slave (
    input  host_wr, host_wdata, host_rd,
    input  seq_wr, seq_wdata, seq_rd,
    input  clr_err,
    output host_rdata, host_rvld, host_full, host_empty, host_irq,
    output seq_rdata, seq_rvld, seq_full, seq_empty, seq_irq,
    output h2s_count, s2h_count, err
  );
endinterface

// File: rtl/useq_mbox.sv
// Bidirectional host <-> sequencer mailbox built from two independent FIFOs.
//   useq_mbox_fifo : one count-based FIFO with registered read data/valid,
//                    registered full/empty and per-cycle reject strobes.
//   useq_mbox      : top; ports clk, rst_n (synchronous, active-low) and the
//                    useq_mbox_if slave modport. H2S is written by the host and
//                    read by the sequencer, S2H the reverse. Adds sticky error
//                    flags {s2h_ovf, s2h_unf, h2s_ovf, h2s_unf} and both irqs.

// Single-clock FIFO; full/empty derive from the occupancy count only.
module useq_mbox_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned CW     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_wr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_rd,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_rvld,
  output logic              o_full,
  output logic              o_empty,
  output logic [CW-1:0]     o_count,
  output logic [CW-1:0]     o_count_nxt_c,
  output logic              o_ovf_c,
  output logic              o_unf_c
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic [CW-1:0]     r_count;
  logic              r_full;
  logic              r_empty;
  logic              r_rvld;
  logic [DATA_W-1:0] r_rdata;

  logic              w_wr_acc;
  logic              w_rd_acc;
  logic [CW-1:0]     w_count_nxt;

  // Acceptance looks at registered flags only: a same-cycle read never frees
  // space for a write, and a same-cycle write never feeds a read.
  always_comb begin
    w_wr_acc    = i_wr & ~r_full;
    w_rd_acc    = i_rd & ~r_empty;
    w_count_nxt = r_count + CW'(w_wr_acc) - CW'(w_rd_acc);
  end

  // Pointers, count, flags and read port.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
      r_rvld  <= 1'b0;
      r_rdata <= '0;
    end else begin
      if (w_wr_acc) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_rd_acc) begin
        r_rptr  <= r_rptr + AW'(1);
        r_rdata <= r_mem[r_rptr];
      end
      r_rvld  <= w_rd_acc;
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CW'(DEPTH));
      r_empty <= (w_count_nxt == '0);
    end
  end

  // Storage array, not reset.
  always_ff @(posedge clk) begin
    if (rst_n && w_wr_acc) begin
      r_mem[r_wptr] <= i_wdata;
    end
  end

  assign o_rdata       = r_rdata;
  assign o_rvld        = r_rvld;
  assign o_full        = r_full;
  assign o_empty       = r_empty;
  assign o_count       = r_count;
  assign o_count_nxt_c = w_count_nxt;
  assign o_ovf_c       = i_wr & r_full;
  assign o_unf_c       = i_rd & r_empty;
endmodule

module useq_mbox #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned IRQ_LEVEL = 1
) (
  input  logic     clk,
  input  logic     rst_n,
  useq_mbox_if.slave mbox
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  // Elaboration-time parameter guards.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("useq_mbox: DEPTH must be a power of two >= 2");
  end
  if (IRQ_LEVEL < 1 || IRQ_LEVEL > DEPTH) begin : g_bad_irq_level
    $error("useq_mbox: IRQ_LEVEL must be in 1..DEPTH");
  end

  logic [CW-1:0] w_h2s_count;
  logic [CW-1:0] w_h2s_count_nxt;
  logic [CW-1:0] w_s2h_count;
  logic [CW-1:0] w_s2h_count_nxt;
  logic          w_h2s_ovf;
  logic          w_h2s_unf;
  logic          w_s2h_ovf;
  logic          w_s2h_unf;
  logic [3:0]    w_err_new;

  logic          r_seq_irq;
  logic          r_host_irq;
  logic [3:0]    r_err;

  // Host -> sequencer FIFO.
  useq_mbox_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .CW     (CW)
  ) u_h2s (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_wr          (mbox.host_wr),
    .i_wdata       (mbox.host_wdata),
    .i_rd          (mbox.seq_rd),
    .o_rdata       (mbox.seq_rdata),
    .o_rvld        (mbox.seq_rvld),
    .o_full        (mbox.host_full),
    .o_empty       (mbox.seq_empty),
    .o_count       (w_h2s_count),
    .o_count_nxt_c (w_h2s_count_nxt),
    .o_ovf_c       (w_h2s_ovf),
    .o_unf_c       (w_h2s_unf)
  );

  // Sequencer -> host FIFO.
  useq_mbox_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .CW     (CW)
  ) u_s2h (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_wr          (mbox.seq_wr),
    .i_wdata       (mbox.seq_wdata),
    .i_rd          (mbox.host_rd),
    .o_rdata       (mbox.host_rdata),
    .o_rvld        (mbox.host_rvld),
    .o_full        (mbox.seq_full),
    .o_empty       (mbox.host_empty),
    .o_count       (w_s2h_count),
    .o_count_nxt_c (w_s2h_count_nxt),
    .o_ovf_c       (w_s2h_ovf),
    .o_unf_c       (w_s2h_unf)
  );

  assign w_err_new = {w_s2h_ovf, w_s2h_unf, w_h2s_ovf, w_h2s_unf};

  // Interrupts and sticky errors; clr_err only drops the held bits, so an
  // error raised in the clearing cycle still lands.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_seq_irq  <= 1'b0;
      r_host_irq <= 1'b0;
      r_err      <= '0;
    end else begin
      r_seq_irq  <= (w_h2s_count == '0) && (w_h2s_count_nxt != '0);
      r_host_irq <= (w_s2h_count_nxt >= CW'(IRQ_LEVEL));
      r_err      <= (mbox.clr_err ? 4'b0000 : r_err) | w_err_new;
    end
  end

  assign mbox.h2s_count = w_h2s_count;
  assign mbox.s2h_count = w_s2h_count;
  assign mbox.seq_irq   = r_seq_irq;
  assign mbox.host_irq  = r_host_irq;
  assign mbox.err       = r_err;
endmodule

// File: tb/tb_useq_mbox.sv
// Directed bench for useq_mbox (DATA_W=8, DEPTH=16, IRQ_LEVEL=4).
module tb_useq_mbox;
  logic clk;
  logic rst_n;

  useq_mbox_if #(.DATA_W(8), .DEPTH(16)) mbox ();

  useq_mbox #(.DATA_W(8), .DEPTH(16), .IRQ_LEVEL(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mbox  (mbox)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       hw;
    logic [7:0] hd;
    logic       hr;
    logic       sw;
    logic [7:0] sd;
    logic       sr;
    logic       ce;
    int         e_h2s;
    int         e_s2h;
    logic       e_sirq;
    logic       e_hirq;
    logic [3:0] e_err;
    logic       e_srvld;
    logic [7:0] e_srd;
    logic       e_hrvld;
    logic [7:0] e_hrd;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    mbox.host_wr    = 1'b0;
    mbox.host_wdata = 8'h00;
    mbox.host_rd    = 1'b0;
    mbox.seq_wr     = 1'b0;
    mbox.seq_wdata  = 8'h00;
    mbox.seq_rd     = 1'b0;
    mbox.clr_err    = 1'b0;
  endtask

  task automatic add(input logic hw, input logic [7:0] hd, input logic hr,
                     input logic sw, input logic [7:0] sd, input logic sr,
                     input logic ce, input int eh2s, input int es2h,
                     input logic esirq, input logic ehirq, input logic [3:0] eerr,
                     input logic esrvld, input logic [7:0] esrd,
                     input logic ehrvld, input logic [7:0] ehrd);
    vec_t v;
    v.hw = hw; v.hd = hd; v.hr = hr; v.sw = sw; v.sd = sd; v.sr = sr; v.ce = ce;
    v.e_h2s = eh2s; v.e_s2h = es2h; v.e_sirq = esirq; v.e_hirq = ehirq;
    v.e_err = eerr; v.e_srvld = esrvld; v.e_srd = esrd;
    v.e_hrvld = ehrvld; v.e_hrd = ehrd;
    vecs.push_back(v);
  endtask

  // Checks the idle/reset view of every status output.
  task automatic check_clean(input string tag);
    check({tag, "_h2s_count"}, 32'(mbox.h2s_count), 32'd0);
    check({tag, "_s2h_count"}, 32'(mbox.s2h_count), 32'd0);
    check({tag, "_seq_empty"}, 32'(mbox.seq_empty), 32'd1);
    check({tag, "_host_empty"}, 32'(mbox.host_empty), 32'd1);
    check({tag, "_host_full"}, 32'(mbox.host_full), 32'd0);
    check({tag, "_seq_full"}, 32'(mbox.seq_full), 32'd0);
    check({tag, "_err"}, 32'(mbox.err), 32'd0);
    check({tag, "_seq_rvld"}, 32'(mbox.seq_rvld), 32'd0);
    check({tag, "_host_rvld"}, 32'(mbox.host_rvld), 32'd0);
    check({tag, "_irqs"}, 32'({mbox.seq_irq, mbox.host_irq}), 32'd0);
  endtask

  logic [7:0] q[$];
  logic [7:0] exp_d;
  logic       do_wr;
  logic       do_rd;
  int         pushed;

  initial begin
    // Test 5/6 table: H2S irq pulse, error stickiness/clear, host_irq level.
    add(1,8'h5C,0, 0,8'h00,0, 0,  1,0, 1,0,4'b0000, 0,8'h00, 0,8'h00);
    add(0,8'h00,0, 0,8'h00,0, 0,  1,0, 0,0,4'b0000, 0,8'h00, 0,8'h00);
    add(1,8'h5D,0, 0,8'h00,0, 0,  2,0, 0,0,4'b0000, 0,8'h00, 0,8'h00);
    add(0,8'h00,0, 0,8'h00,1, 0,  1,0, 0,0,4'b0000, 1,8'h5C, 0,8'h00);
    add(0,8'h00,0, 0,8'h00,1, 0,  0,0, 0,0,4'b0000, 1,8'h5D, 0,8'h00);
    add(0,8'h00,0, 0,8'h00,1, 0,  0,0, 0,0,4'b0001, 0,8'h00, 0,8'h00);
    add(0,8'h00,0, 0,8'h00,0, 1,  0,0, 0,0,4'b0000, 0,8'h00, 0,8'h00);
    add(0,8'h00,0, 0,8'h00,1, 1,  0,0, 0,0,4'b0001, 0,8'h00, 0,8'h00);
    add(0,8'h00,0, 0,8'h00,0, 1,  0,0, 0,0,4'b0000, 0,8'h00, 0,8'h00);
    add(0,8'h00,0, 1,8'hA1,0, 0,  0,1, 0,0,4'b0000, 0,8'h00, 0,8'h00);
    add(0,8'h00,0, 1,8'hA2,0, 0,  0,2, 0,0,4'b0000, 0,8'h00, 0,8'h00);
    add(0,8'h00,0, 1,8'hA3,0, 0,  0,3, 0,0,4'b0000, 0,8'h00, 0,8'h00);
    add(0,8'h00,0, 1,8'hA4,0, 0,  0,4, 0,1,4'b0000, 0,8'h00, 0,8'h00);
    add(0,8'h00,1, 0,8'h00,0, 0,  0,3, 0,0,4'b0000, 0,8'h00, 1,8'hA1);
    add(0,8'h00,0, 0,8'h00,0, 0,  0,3, 0,0,4'b0000, 0,8'h00, 0,8'h00);
    add(0,8'h00,0, 0,8'h00,1, 0,  0,3, 0,0,4'b0001, 0,8'h00, 0,8'h00);
    add(0,8'h00,0, 0,8'h00,0, 1,  0,3, 0,0,4'b0000, 0,8'h00, 0,8'h00);
    add(0,8'h00,1, 1,8'hA5,0, 0,  0,3, 0,0,4'b0000, 0,8'h00, 1,8'hA2);
    add(0,8'h00,0, 1,8'hA6,0, 0,  0,4, 0,1,4'b0000, 0,8'h00, 0,8'h00);
    add(1,8'h77,1, 1,8'hA7,1, 0,  1,4, 1,1,4'b0001, 0,8'h00, 1,8'hA3);
    add(0,8'h00,0, 0,8'h00,1, 1,  0,4, 0,1,4'b0000, 1,8'h77, 0,8'h00);
    add(0,8'h00,1, 0,8'h00,0, 0,  0,3, 0,0,4'b0000, 0,8'h00, 1,8'hA4);
    add(0,8'h00,1, 0,8'h00,0, 0,  0,2, 0,0,4'b0000, 0,8'h00, 1,8'hA5);
    add(0,8'h00,1, 0,8'h00,0, 0,  0,1, 0,0,4'b0000, 0,8'h00, 1,8'hA6);
    add(0,8'h00,1, 0,8'h00,0, 0,  0,0, 0,0,4'b0000, 0,8'h00, 1,8'hA7);
    add(0,8'h00,1, 0,8'h00,0, 0,  0,0, 0,0,4'b0100, 0,8'h00, 0,8'h00);
    add(0,8'h00,0, 0,8'h00,0, 1,  0,0, 0,0,4'b0000, 0,8'h00, 0,8'h00);

    // 1. Reset window with every request active.
    rst_n = 1'b0;
    idle();
    mbox.host_wr = 1'b1; mbox.host_wdata = 8'hEE;
    mbox.host_rd = 1'b1; mbox.seq_wr = 1'b1; mbox.seq_rd = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_clean("reset");
    end
    idle();
    rst_n = 1'b1;
    tick();
    check_clean("post_reset");

    // 2. Fill H2S, overflow, drain in order.
    for (int i = 1; i <= 16; i++) begin
      mbox.host_wr = 1'b1; mbox.host_wdata = 8'(i);
      tick();
      check("fill_count", 32'(mbox.h2s_count), 32'(i));
      check("fill_full", 32'(mbox.host_full), 32'(i == 16));
      check("fill_seq_irq", 32'(mbox.seq_irq), 32'(i == 1));
    end
    mbox.host_wdata = 8'hAA;
    tick();
    check("ovf_count", 32'(mbox.h2s_count), 32'd16);
    check("ovf_err", 32'(mbox.err), 32'b0010);
    idle();
    for (int i = 1; i <= 16; i++) begin
      mbox.seq_rd = 1'b1;
      tick();
      check("drain_rvld", 32'(mbox.seq_rvld), 32'd1);
      check("drain_data", 32'(mbox.seq_rdata), 32'(i));
      check("drain_count", 32'(mbox.h2s_count), 32'(16 - i));
    end
    idle();
    tick();
    check("drain_rvld_drop", 32'(mbox.seq_rvld), 32'd0);
    check("drain_rdata_hold", 32'(mbox.seq_rdata), 32'h10);
    check("drain_empty", 32'(mbox.seq_empty), 32'd1);
    check("drain_full", 32'(mbox.host_full), 32'd0);
    mbox.clr_err = 1'b1;
    tick();
    check("clr_err", 32'(mbox.err), 32'd0);
    idle();

    // 3. 40 beats, occupancy <= 3, across pointer wrap.
    pushed = 0;
    q.delete();
    for (int c = 0; c < 200 && !(pushed == 40 && q.size() == 0); c++) begin
      do_wr = (pushed < 40) && (q.size() < 3);
      do_rd = (q.size() > 0) && (c % 3 != 0);
      exp_d = 8'h00;
      if (do_rd) exp_d = q.pop_front();
      mbox.host_wr = do_wr;
      mbox.host_wdata = 8'(8'h30 + pushed);
      if (do_wr) begin
        q.push_back(8'(8'h30 + pushed));
        pushed++;
      end
      mbox.seq_rd = do_rd;
      tick();
      check("wrap_count", 32'(mbox.h2s_count), 32'(q.size()));
      check("wrap_rvld", 32'(mbox.seq_rvld), 32'(do_rd));
      if (do_rd) check("wrap_data", 32'(mbox.seq_rdata), 32'(exp_d));
    end
    idle();
    check("wrap_done", 32'(pushed == 40 && q.size() == 0), 32'd1);
    check("wrap_empty", 32'(mbox.seq_empty), 32'd1);

    // 4. Hold at 8 with simultaneous read and write.
    for (int i = 0; i < 8; i++) begin
      mbox.host_wr = 1'b1; mbox.host_wdata = 8'(8'h80 + i);
      q.push_back(8'(8'h80 + i));
      tick();
    end
    check("steady_fill", 32'(mbox.h2s_count), 32'd8);
    for (int k = 0; k < 10; k++) begin
      exp_d = q.pop_front();
      mbox.host_wr = 1'b1; mbox.host_wdata = 8'(8'h90 + k);
      q.push_back(8'(8'h90 + k));
      mbox.seq_rd = 1'b1;
      tick();
      check("steady_count", 32'(mbox.h2s_count), 32'd8);
      check("steady_rvld", 32'(mbox.seq_rvld), 32'd1);
      check("steady_data", 32'(mbox.seq_rdata), 32'(exp_d));
    end
    idle();
    for (int i = 0; i < 8; i++) begin
      exp_d = q.pop_front();
      mbox.seq_rd = 1'b1;
      tick();
      check("steady_drain", 32'(mbox.seq_rdata), 32'(exp_d));
    end
    idle();
    tick();
    check("steady_empty", 32'(mbox.h2s_count), 32'd0);
    check("steady_err", 32'(mbox.err), 32'd0);

    // 5/6. Table.
    foreach (vecs[i]) begin
      mbox.host_wr = vecs[i].hw; mbox.host_wdata = vecs[i].hd; mbox.host_rd = vecs[i].hr;
      mbox.seq_wr = vecs[i].sw; mbox.seq_wdata = vecs[i].sd; mbox.seq_rd = vecs[i].sr;
      mbox.clr_err = vecs[i].ce;
      tick();
      check($sformatf("v%0d_h2s", i), 32'(mbox.h2s_count), 32'(vecs[i].e_h2s));
      check($sformatf("v%0d_s2h", i), 32'(mbox.s2h_count), 32'(vecs[i].e_s2h));
      check($sformatf("v%0d_seq_irq", i), 32'(mbox.seq_irq), 32'(vecs[i].e_sirq));
      check($sformatf("v%0d_host_irq", i), 32'(mbox.host_irq), 32'(vecs[i].e_hirq));
      check($sformatf("v%0d_err", i), 32'(mbox.err), 32'(vecs[i].e_err));
      check($sformatf("v%0d_seq_rvld", i), 32'(mbox.seq_rvld), 32'(vecs[i].e_srvld));
      check($sformatf("v%0d_host_rvld", i), 32'(mbox.host_rvld), 32'(vecs[i].e_hrvld));
      check($sformatf("v%0d_seq_empty", i), 32'(mbox.seq_empty), 32'(vecs[i].e_h2s == 0));
      check($sformatf("v%0d_host_empty", i), 32'(mbox.host_empty), 32'(vecs[i].e_s2h == 0));
      if (vecs[i].e_srvld) check($sformatf("v%0d_seq_rdata", i), 32'(mbox.seq_rdata), 32'(vecs[i].e_srd));
      if (vecs[i].e_hrvld) check($sformatf("v%0d_host_rdata", i), 32'(mbox.host_rdata), 32'(vecs[i].e_hrd));
    end
    idle();

    // S2H overflow.
    for (int i = 0; i < 17; i++) begin
      mbox.seq_wr = 1'b1; mbox.seq_wdata = 8'(8'hC0 + i);
      tick();
      if (i == 15) check("s2h_full", 32'(mbox.seq_full), 32'd1);
    end
    idle();
    check("s2h_ovf_err", 32'(mbox.err), 32'b1000);
    check("s2h_ovf_count", 32'(mbox.s2h_count), 32'd16);
    check("s2h_ovf_irq", 32'(mbox.host_irq), 32'd1);

    // Reset with the mailbox full and all ports active.
    rst_n = 1'b0;
    mbox.host_wr = 1'b1; mbox.host_rd = 1'b1; mbox.seq_wr = 1'b1; mbox.seq_rd = 1'b1;
    tick();
    check_clean("mid_reset");
    idle();
    rst_n = 1'b1;
    tick();
    check_clean("after_mid_reset");
    mbox.seq_wr = 1'b1; mbox.seq_wdata = 8'h3C;
    tick();
    idle();
    mbox.host_rd = 1'b1;
    tick();
    check("fresh_rvld", 32'(mbox.host_rvld), 32'd1);
    check("fresh_data", 32'(mbox.host_rdata), 32'h3C);
    check("fresh_count", 32'(mbox.s2h_count), 32'd0);
    idle();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
